// File: rtl/j_bustgt_pkg.sv
// Shared encodings and constants for the DSP bus target.
package j_bustgt_pkg;

    localparam logic [1:0] SIZ_BYTE = 2'b00;
    localparam logic [1:0] SIZ_WORD = 2'b01;
    localparam logic [1:0] SIZ_LONG = 2'b10;

    localparam int CNTW = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WAIT,
        ST_ACK,
        ST_HOLD
    } state_t;

    // Right-justified data mask for a transfer size; 2'b11 behaves as long.
    function automatic logic [31:0] siz_mask(input logic [1:0] siz);
        case (siz)
            SIZ_BYTE: siz_mask = 32'h0000_00ff;
            SIZ_WORD: siz_mask = 32'h0000_ffff;
            default:  siz_mask = 32'hffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/j_dsp_bus_target_if.sv
// DSP external-memory bus between the DSP master and the system-side target.
// J_BUSTGT_MISALIGN_EN adds the err return signal.
interface j_dsp_bus_target_if #(
    parameter int AW = 10
);
    logic          dreql;
    logic          rw;
    logic [1:0]    siz;
    logic [AW+1:0] addr;
    logic          bigend;
    logic [31:0]   wdata;
    logic          dbgl;
    logic          dtackl;
    logic [31:0]   rdata;
    logic          busy;
`ifdef J_BUSTGT_MISALIGN_EN
    logic          err;
`endif

    modport master (
`ifdef J_BUSTGT_MISALIGN_EN
        input  err,
`endif
        output dreql, rw, siz, addr, bigend, wdata,
        input  dbgl, dtackl, rdata, busy
    );

    modport slave (
`ifdef J_BUSTGT_MISALIGN_EN
        output err,
`endif
        input  dreql, rw, siz, addr, bigend, wdata,
        output dbgl, dtackl, rdata, busy
    );

endinterface

// File: rtl/j_bustgt_lane.sv
// Byte-lane decode: size, low address and byte order to lane enables and shift.
// J_BUSTGT_MISALIGN_EN adds the misalign flag for odd words / unaligned longs.
module j_bustgt_lane
    import j_bustgt_pkg::*;
(
    input  logic [1:0] siz,
    input  logic [1:0] addr_lo,
    input  logic       bigend,
    output logic [3:0] be,
    output logic [1:0] sh
`ifdef J_BUSTGT_MISALIGN_EN
    ,
    output logic       misalign
`endif
);
    logic [1:0] ba;

    assign ba = addr_lo ^ {2{bigend}};

    always_comb begin
        be = 4'b1111;
        sh = 2'b00;
        case (siz)
            SIZ_BYTE: begin
                be = 4'b0001 << ba;
                sh = ba;
            end
            SIZ_WORD: begin
                be = ba[1] ? 4'b1100 : 4'b0011;
                sh = {ba[1], 1'b0};
            end
            default: begin
                be = 4'b1111;
                sh = 2'b00;
            end
        endcase
    end

`ifdef J_BUSTGT_MISALIGN_EN
    // Alignment is judged on the raw address, independent of byte order.
    assign misalign = ((siz == SIZ_WORD) && addr_lo[0]) ||
                      (siz[1] && (addr_lo != 2'b00));
`endif

endmodule

// File: rtl/j_dsp_bus_target.sv
// System-side responder for the DSP dreql/dbgl/dtackl master with a local longword RAM.
// J_BUSTGT_MISALIGN_EN: misaligned word/long accesses ack with err=1 and transfer nothing.
//
// state | meaning
// IDLE  | bus released, waiting for dreql
// ARB   | request seen, grant delay counting down
// WAIT  | granted, wait states counting down
// ACK   | dtackl low for one ce-cycle, data moved
// HOLD  | grant kept, waiting for a follow-on request or expiry
module j_dsp_bus_target
    import j_bustgt_pkg::*;
#(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 2,
    parameter int GRANT_DLY   = 1,
    parameter int HOLD_CYCLES = 3
) (
    input  logic              sys_clk,
    input  logic              resetl,
    input  logic              ce,
    j_dsp_bus_target_if.slave bus
);
    localparam logic [CNTW-1:0] GRANT_INIT = CNTW'(GRANT_DLY - 1);
    localparam logic [CNTW-1:0] WAIT_INIT  = CNTW'(WAIT_STATES);
    localparam logic [CNTW-1:0] HOLD_INIT  = CNTW'(HOLD_CYCLES);

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            dbgl_q, dbgl_d;
    logic            dtackl_q, dtackl_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            ram_we;
    logic [31:0]     ram_q [2**AW];
    logic [AW-1:0]   ram_a;
    logic [3:0]      be;
    logic [1:0]      sh;
    logic            misalign;
    logic [31:0]     rd_val;
    logic [31:0]     wr_val;
`ifdef J_BUSTGT_MISALIGN_EN
    logic            err_q, err_d;
`endif

    j_bustgt_lane u_lane (
        .siz     (bus.siz),
        .addr_lo (bus.addr[1:0]),
        .bigend  (bus.bigend),
        .be      (be),
        .sh      (sh)
`ifdef J_BUSTGT_MISALIGN_EN
        ,
        .misalign(misalign)
`endif
    );

`ifndef J_BUSTGT_MISALIGN_EN
    assign misalign = 1'b0;
`endif

    assign ram_a  = bus.addr[AW+1:2];
    assign rd_val = (ram_q[ram_a] >> {sh, 3'b000}) & siz_mask(bus.siz);
    assign wr_val = bus.wdata << {sh, 3'b000};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dbgl_d   = dbgl_q;
        dtackl_d = dtackl_q;
        rdata_d  = rdata_q;
        ram_we   = 1'b0;
`ifdef J_BUSTGT_MISALIGN_EN
        err_d    = err_q;
`endif
        if (ce) begin
            dtackl_d = 1'b1;
`ifdef J_BUSTGT_MISALIGN_EN
            err_d    = 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (!bus.dreql) begin
                        state_d = ST_ARB;
                        cnt_d   = GRANT_INIT;
                    end
                end
                ST_ARB: begin
                    if (bus.dreql) begin
                        state_d = ST_IDLE;
                        dbgl_d  = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                        dbgl_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                ST_WAIT: begin
                    if (bus.dreql) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_INIT;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNTW'(1);
                    end else begin
                        // Data moves on the edge that opens the ACK cycle.
                        state_d  = ST_ACK;
                        dtackl_d = 1'b0;
`ifdef J_BUSTGT_MISALIGN_EN
                        err_d    = misalign;
`endif
                        if (bus.rw) begin
                            rdata_d = misalign ? 32'h0 : rd_val;
                        end else begin
                            ram_we = !misalign;
                        end
                    end
                end
                ST_ACK: begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_INIT;
                end
                ST_HOLD: begin
                    // A new request beats an expiring hold.
                    if (!bus.dreql) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        dbgl_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    dbgl_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dbgl_q   <= 1'b1;
            dtackl_q <= 1'b1;
            rdata_q  <= '0;
`ifdef J_BUSTGT_MISALIGN_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dbgl_q   <= dbgl_d;
            dtackl_q <= dtackl_d;
            rdata_q  <= rdata_d;
`ifdef J_BUSTGT_MISALIGN_EN
            err_q    <= err_d;
`endif
        end
    end

    // A reset on the ack edge must not leave a half-committed write behind.
    always_ff @(posedge sys_clk) begin
        if (resetl && ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    ram_q[ram_a][8*i +: 8] <= wr_val[8*i +: 8];
                end
            end
        end
    end

    assign bus.dbgl   = dbgl_q;
    assign bus.dtackl = dtackl_q;
    assign bus.rdata  = rdata_q;
    assign bus.busy   = (state_q != ST_IDLE);
`ifdef J_BUSTGT_MISALIGN_EN
    assign bus.err    = err_q;
`endif

endmodule

// File: tb/tb_j_dsp_bus_target.sv
// Self-checking bench for j_dsp_bus_target: directed protocol cases plus random
// transfers against a byte-lane memory model.
module tb_j_dsp_bus_target;
    import j_bustgt_pkg::*;

    localparam int AW = 10;
    localparam int WS = 2;
    localparam int GD = 1;
    localparam int HC = 3;
`ifdef J_BUSTGT_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic resetl;
    logic ce;
    int   n_chk = 0;
    int   n_err = 0;

    logic [31:0] mdl [int];

    j_dsp_bus_target_if #(.AW(AW)) bus ();

    j_dsp_bus_target #(
        .AW(AW), .WAIT_STATES(WS), .GRANT_DLY(GD), .HOLD_CYCLES(HC)
    ) dut (
        .sys_clk(sys_clk),
        .resetl (resetl),
        .ce     (ce),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Reference model: memory is a longword array, accesses are byte-by-byte lane moves.
    function automatic bit is_mis(input logic [1:0] s, input logic [1:0] a);
        return MIS_EN && (((s == 2'b01) && a[0]) || (s[1] && (a != 2'b00)));
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic int lane_of(input logic [1:0] s, input logic [1:0] a, input logic bg, input int k);
        int ba;
        ba = int'(a) ^ (bg ? 3 : 0);
        if (s == 2'b00) return ba;
        if (s == 2'b01) return (ba & 2) + k;
        return k;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [1:0] s, input logic [AW+1:0] a, input logic bg);
        logic [31:0] w;
        logic [31:0] r;
        w = mdl[int'(a[AW+1:2])];
        r = '0;
        if (is_mis(s, a[1:0])) return '0;
        for (int k = 0; k < nbytes(s); k++) r[8*k +: 8] = w[8*lane_of(s, a[1:0], bg, k) +: 8];
        return r;
    endfunction

    function automatic void mdl_write(input logic [1:0] s, input logic [AW+1:0] a, input logic bg,
                                      input logic [31:0] d);
        logic [31:0] w;
        if (is_mis(s, a[1:0])) return;
        w = mdl[int'(a[AW+1:2])];
        for (int k = 0; k < nbytes(s); k++) w[8*lane_of(s, a[1:0], bg, k) +: 8] = d[8*k +: 8];
        mdl[int'(a[AW+1:2])] = w;
    endfunction

    // One request/ack pair; returns one edge after the ack with dreql released.
    task automatic xfer(input logic rw_i, input logic [1:0] s, input logic [AW+1:0] a, input logic bg,
                        input logic [31:0] wd, input bit held, output logic [31:0] rd);
        int n;
        int n_gnt;
        bit lost;
        logic [31:0] exp_rd;
        exp_rd = mdl_read(s, a, bg);
        bus.rw = rw_i; bus.siz = s; bus.addr = a; bus.bigend = bg; bus.wdata = wd;
        bus.dreql = 1'b0;
        n = -1; n_gnt = -1; lost = 1'b0;
        do begin
            @(posedge sys_clk);
            #1;
            n++;
            if (!bus.dbgl && n_gnt < 0) n_gnt = n;
            if (held && bus.dbgl) lost = 1'b1;
        end while (bus.dtackl && n < 64);
        rd = bus.rdata;
        if (held) chk("grant_held", 32'(lost), 32'd0);
        else      chk("grant_lat", n_gnt, GD);
        chk("ack_lat", n, held ? WS + 1 : GD + WS + 1);
        if (rw_i) chk("rdata", rd, exp_rd);
`ifdef J_BUSTGT_MISALIGN_EN
        chk("err", 32'(bus.err), 32'(is_mis(s, a[1:0])));
`endif
        if (!rw_i) mdl_write(s, a, bg, wd);
        bus.dreql = 1'b1;
        tick(1);
        chk("ack_width", 32'(bus.dtackl), 32'd1);
    endtask

    task automatic wait_release(input string tag, input int exp_n);
        int n;
        bit ack_seen;
        n = 0; ack_seen = 1'b0;
        while (!bus.dbgl && n < 64) begin
            tick(1);
            n++;
            if (!bus.dtackl) ack_seen = 1'b1;
        end
        chk(tag, n, exp_n);
        chk({tag, "_noack"}, 32'(ack_seen), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [31:0]   rd;
        logic [AW+1:0] a;
        logic [1:0]    s;
        logic          rw_r;
        bit            held;
        bit            frz_bad;
        int            n;
        int            g;

        resetl = 1'b0; ce = 1'b1;
        bus.dreql = 1'b1; bus.rw = 1'b1; bus.siz = SIZ_BYTE; bus.addr = '0;
        bus.bigend = 1'b0; bus.wdata = '0;
        tick(3);
        chk("rst_dbgl", 32'(bus.dbgl), 32'd1);
        chk("rst_dtackl", 32'(bus.dtackl), 32'd1);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        resetl = 1'b1;
        tick(1);

        xfer(1'b0, SIZ_LONG, 'h10, 1'b0, 32'h1234_5678, 1'b0, rd);
        wait_release("rel_wr", HC + 1);
        xfer(1'b1, SIZ_LONG, 'h10, 1'b0, 32'h0, 1'b0, rd);
        chk("long_rd", rd, 32'h1234_5678);
        wait_release("rel_rd", HC + 1);

        // Byte write, then a read arriving in HOLD with no re-arbitration.
        xfer(1'b0, SIZ_BYTE, 'h11, 1'b0, 32'h0000_00ab, 1'b0, rd);
        xfer(1'b1, SIZ_LONG, 'h10, 1'b0, 32'h0, 1'b1, rd);
        chk("byte_le", rd, 32'h1234_ab78);
        wait_release("rel_b2b", HC + 1);

        // Big-endian byte write; follow-on request lands on the HOLD expiry edge.
        xfer(1'b0, SIZ_BYTE, 'h11, 1'b1, 32'h0000_00cd, 1'b0, rd);
        tick(HC);
        xfer(1'b1, SIZ_LONG, 'h10, 1'b0, 32'h0, 1'b1, rd);
        chk("byte_be", rd, 32'h12cd_ab78);
        wait_release("rel_exp", HC + 1);

        // Reset in WAIT of a write.
        bus.rw = 1'b0; bus.siz = SIZ_LONG; bus.addr = 'h10; bus.bigend = 1'b0;
        bus.wdata = 32'hdead_beef; bus.dreql = 1'b0;
        n = 0;
        while (bus.dbgl && n < 16) begin tick(1); n++; end
        chk("rstw_gnt", 32'(bus.dbgl), 32'd0);
        resetl = 1'b0; bus.dreql = 1'b1;
        tick(1);
        chk("rstw_dbgl", 32'(bus.dbgl), 32'd1);
        chk("rstw_dtackl", 32'(bus.dtackl), 32'd1);
        chk("rstw_busy", 32'(bus.busy), 32'd0);
        resetl = 1'b1;
        tick(1);
        xfer(1'b1, SIZ_LONG, 'h10, 1'b0, 32'h0, 1'b0, rd);
        chk("rstw_nowrite", rd, 32'h12cd_ab78);
        wait_release("rel_rstw", HC + 1);

        // Request dropped in WAIT.
        bus.rw = 1'b0; bus.siz = SIZ_LONG; bus.addr = 'h10; bus.wdata = 32'hdead_beef; bus.dreql = 1'b0;
        n = 0;
        while (bus.dbgl && n < 16) begin tick(1); n++; end
        chk("abort_gnt", 32'(bus.dbgl), 32'd0);
        bus.dreql = 1'b1;
        wait_release("rel_abort", HC + 2);
        xfer(1'b1, SIZ_LONG, 'h10, 1'b0, 32'h0, 1'b0, rd);
        chk("abort_nowrite", rd, 32'h12cd_ab78);
        wait_release("rel_abort_rd", HC + 1);

        // ce low freezes the transfer mid-wait.
        bus.rw = 1'b1; bus.siz = SIZ_LONG; bus.addr = 'h10; bus.dreql = 1'b0;
        n = 0;
        while (bus.dbgl && n < 16) begin tick(1); n++; end
        chk("frz_gnt", 32'(bus.dbgl), 32'd0);
        ce = 1'b0; frz_bad = 1'b0;
        repeat (6) begin
            tick(1);
            if (bus.dtackl !== 1'b1 || bus.dbgl !== 1'b0 || bus.busy !== 1'b1) frz_bad = 1'b1;
        end
        chk("freeze", 32'(frz_bad), 32'd0);
        ce = 1'b1;
        n = 0;
        while (bus.dtackl && n < 16) begin tick(1); n++; end
        chk("frz_ack_lat", n, WS + 1);
        chk("frz_rdata", bus.rdata, 32'h12cd_ab78);
        bus.dreql = 1'b1;
        tick(1);
        wait_release("rel_frz", HC + 1);

`ifdef J_BUSTGT_MISALIGN_EN
        xfer(1'b0, SIZ_WORD, 'h13, 1'b0, 32'h0000_beef, 1'b0, rd);
        wait_release("rel_mis", HC + 1);
        xfer(1'b1, SIZ_LONG, 'h10, 1'b0, 32'h0, 1'b0, rd);
        chk("mis_nowrite", rd, 32'h12cd_ab78);
        wait_release("rel_mis_rd", HC + 1);
`endif

        // Random traffic over eight longwords at byte address 0x40.
        held = 1'b0;
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, SIZ_LONG, (AW+2)'(32'h40 + 4 * i), 1'b0, $urandom, held, rd);
            g = $urandom_range(1, HC + 3);
            tick(g - 1);
            held = (g <= HC + 1);
        end
        for (int i = 0; i < 60; i++) begin
            rw_r = 1'($urandom_range(0, 1));
            s    = 2'($urandom_range(0, 3));
            a    = (AW+2)'(32'h40 + $urandom_range(0, 31));
            xfer(rw_r, s, a, 1'($urandom_range(0, 1)), $urandom, held, rd);
            g = $urandom_range(1, HC + 3);
            tick(g - 1);
            held = (g <= HC + 1);
        end
        for (int i = 0; i < 8; i++) begin
            xfer(1'b1, SIZ_LONG, (AW+2)'(32'h40 + 4 * i), 1'b0, 32'h0, held, rd);
            held = 1'b1;
        end
        wait_release("rel_final", HC + 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
